data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 38 +++
 rtl/data_sram_resp_sram_bytewe.sv | 29 ++
 rtl/data_sram_resp.sv | 117 +++++++++++
 3 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data SRAM responder: bus widths, FSM state
// encodings, access-size codes and alignment helpers.
package data_sram_resp_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Size code 3 is undefined and treated as misaligned so it never writes.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_aligned = 1'b1;
      SIZE_HALF: is_aligned = ~lo[0];
      SIZE_WORD: is_aligned = (lo == 2'b00);
      default:   is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = 32'h0000_00FF;
      SIZE_HALF: size_mask = 32'h0000_FFFF;
      SIZE_WORD: size_mask = 32'hFFFF_FFFF;
      default:   size_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_resp_sram_bytewe.sv
// Single-port word array with per-byte write enables and combinational read.
// Each byte lane is its own array so every lane has exactly one writer.
module sram_bytewe
  import data_sram_resp_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic [STRB_W-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        mem[addr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = mem[addr];
  end

endmodule

// File: rtl/data_sram_resp.sv
// Fixed-latency data SRAM responder: accepts one request at a time, answers
// exactly LAT cycles later with right-aligned load data or a store completion.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int AW  = 12,
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = (LAT > 1) ? CNT_W'(LAT - 2) : '0;
  localparam state_t ST_ACCEPT = (LAT == 1) ? ST_RESP : ST_WAIT;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic                wr_reg;
  logic [1:0]          size_reg;
  logic [AW+1:0]       addr_reg;
  logic [STRB_W-1:0]   wstrb_reg;
  logic [DATA_W-1:0]   wdata_reg;

  logic                accept;
  logic                aligned;
  logic [STRB_W-1:0]   mem_we;
  logic [DATA_W-1:0]   mem_rdata;
  logic [DATA_W-1:0]   shifted;
  logic                unused_addr_bits;

  assign accept           = data_sram_req & data_sram_addr_ok;
  assign unused_addr_bits = ^data_sram_addr[31:AW+2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_ACCEPT;
      ST_WAIT: if (cnt_reg == '0) state_next = ST_RESP;
      ST_RESP: state_next = accept ? ST_ACCEPT : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    data_sram_addr_ok = 1'b1;
    data_sram_data_ok = 1'b0;
    case (state_reg)
      ST_IDLE: begin data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b0; end
      ST_WAIT: begin data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; end
      ST_RESP: begin data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; end
      default: begin data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= CNT_LOAD;
    end else if (state_reg == ST_WAIT && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Request fields are held here so the requester may move on after acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_reg    <= 1'b0;
      size_reg  <= '0;
      addr_reg  <= '0;
      wstrb_reg <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      wr_reg    <= data_sram_wr;
      size_reg  <= data_sram_size;
      addr_reg  <= data_sram_addr[AW+1:0];
      wstrb_reg <= data_sram_wstrb;
      wdata_reg <= data_sram_wdata;
    end
  end

  assign aligned = is_aligned(size_reg, addr_reg[1:0]);
  assign mem_we  = (state_reg == ST_RESP && wr_reg && aligned) ? wstrb_reg : '0;

  sram_bytewe #(
    .AW(AW)
  ) u_sram (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_reg[AW+1:2]),
    .wdata(wdata_reg),
    .rdata(mem_rdata)
  );

  // Bytes beyond the access size are zeroed so a byte/half load is clean.
  assign shifted = mem_rdata >> {addr_reg[1:0], 3'b000};
  assign data_sram_rdata = (data_sram_data_ok && !wr_reg && aligned)
                           ? (shifted & size_mask(size_reg)) : '0;

endmodule
